// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
package pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // Bits handled by one pipeline stage.
  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_chunk_adder.sv
// C-bit combinational adder slice with carry in and carry out.
module chunk_adder #(
  parameter int unsigned C = 4
) (
  input  logic [C-1:0] i_a,
  input  logic [C-1:0] i_b,
  input  logic         i_cin,
  output logic [C-1:0] o_sum_c,
  output logic         o_cout_c
);

  logic [C:0] w_full;

  assign w_full             = {1'b0, i_a} + {1'b0, i_b} + (C+1)'(i_cin);
  assign {o_cout_c, o_sum_c} = w_full;

endmodule

// File: rtl/pipe_adder.sv
// Carry-chunked pipelined adder with a global stall; optional saturation of
// the sum on overflow when PIPE_ADDER_SAT_EN is defined.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned C = chunk_w(WIDTH, STAGES);

  logic w_en;

  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  // Stage k consumes the lowest remaining operand chunk, forwards the rest,
  // and appends its sum chunk above the chunks already completed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IW = WIDTH - k * C;
    localparam int unsigned SW = (k + 1) * C;

    logic [IW-1:0] w_pa;
    logic [IW-1:0] w_pb;
    logic          w_pc;
    logic          w_pv;
    logic [C-1:0]  w_cs;
    logic          w_cc;
    logic [SW-1:0] w_raw;
    logic [SW-1:0] w_ns;
    logic [SW-1:0] r_s;
    logic          r_c;
    logic          r_v;

    if (k == 0) begin : g_first
      assign w_pa  = a;
      assign w_pb  = b;
      assign w_pc  = cin;
      assign w_pv  = in_valid;
      assign w_raw = w_cs;
    end else begin : g_next
      assign w_pa  = g_stage[k-1].g_ops.r_a;
      assign w_pb  = g_stage[k-1].g_ops.r_b;
      assign w_pc  = g_stage[k-1].r_c;
      assign w_pv  = g_stage[k-1].r_v;
      assign w_raw = {w_cs, g_stage[k-1].r_s};
    end

    chunk_adder #(.C(C)) u_chunk (
      .i_a      (w_pa[C-1:0]),
      .i_b      (w_pb[C-1:0]),
      .i_cin    (w_pc),
      .o_sum_c  (w_cs),
      .o_cout_c (w_cc)
    );

`ifdef PIPE_ADDER_SAT_EN
    if (k == STAGES - 1) begin : g_sat
      assign w_ns = w_cc ? '1 : w_raw;
    end else begin : g_nosat
      assign w_ns = w_raw;
    end
`else
    assign w_ns = w_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_en) begin
        r_s <= w_ns;
        r_c <= w_cc;
        r_v <= w_pv;
      end
    end

    // Upper operand chunks travel alongside the carry until their stage.
    if (IW > C) begin : g_ops
      logic [IW-C-1:0] r_a;
      logic [IW-C-1:0] r_b;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_pa[IW-1:C];
          r_b <= w_pb[IW-1:C];
        end
      end
    end
  end

  assign sum       = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign out_valid = g_stage[STAGES-1].r_v;

endmodule
